rv32_instr_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of rv32_decoder.
- Owns the program counter and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a 2-entry FIFO and presents {instr, instr_pc} to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump/trap target) from execute that flushes all in-flight and buffered instructions.

---
 rtl/rv32_instr_fetch.sv | 127 ++++++++++++
 tb/tb_rv32_instr_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_instr_fetch
//  Description : RV32 instruction-fetch stage. Owns the PC, issues word reads
//                to a 1-cycle synchronous instruction memory, buffers returned
//                words in a 2-entry FIFO and hands {instr, pc} to decode over
//                valid/ready. A redirect from execute flushes everything.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_instr_fetch #(
    parameter int unsigned          XPR_LEN         = 32,
    parameter logic [XPR_LEN-1:0]   RESET_PC        = 32'h0000_0000,
    parameter int unsigned          IMEM_ADDR_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    // instruction memory
    output logic                        imem_req_o,
    output logic [IMEM_ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic [XPR_LEN-1:0]          imem_rdata_i,
    // redirect from execute
    input  logic                        redirect_valid_i,
    input  logic [XPR_LEN-1:0]          redirect_pc_i,
    // decode handshake
    output logic                        instr_valid_o,
    input  logic                        instr_ready_i,
    output logic [XPR_LEN-1:0]          instr_o,
    output logic [XPR_LEN-1:0]          instr_pc_o
);

    localparam logic [XPR_LEN-1:0] PC_STEP       = XPR_LEN'(4);
    localparam logic [XPR_LEN-1:0] PC_ALIGN_MASK = XPR_LEN'(3);
    localparam logic [1:0]         FIFO_FULL     = 2'd2;

    logic [XPR_LEN-1:0] pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [XPR_LEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]         count_q, count_d;
    logic               rd_ptr_q, wr_ptr_q;
    logic [XPR_LEN-1:0] fifo_instr_q [2];
    logic [XPR_LEN-1:0] fifo_pc_q    [2];

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [2:0]         w_occupancy;

    // Handshake, issue decision and FIFO head presentation.
    always_comb begin
        instr_valid_o = !rst && (count_q != 2'd0);
        w_pop         = instr_valid_o && instr_ready_i;
        // The word fetched last cycle lands now unless a redirect kills it.
        w_push        = inflight_q && !redirect_valid_i;
        // Buffered + outstanding words never exceed the 2 FIFO slots; a pop
        // this cycle frees a slot so fetch can continue without a bubble.
        w_occupancy   = {1'b0, count_q} + {2'b00, inflight_q};
        w_issue       = !rst && !redirect_valid_i && ((w_occupancy < 3'd2) || w_pop);
        imem_req_o    = w_issue;
        imem_addr_o   = pc_q[IMEM_ADDR_WIDTH+1:2];
        instr_o       = fifo_instr_q[rd_ptr_q];
        instr_pc_o    = fifo_pc_q[rd_ptr_q];
    end

    // Next-state for PC, in-flight tracking and FIFO occupancy; redirect wins.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = w_issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        if (redirect_valid_i) begin
            pc_d       = redirect_pc_i & ~PC_ALIGN_MASK;
            inflight_d = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (w_issue) begin
                pc_d          = pc_q + PC_STEP;
                inflight_pc_d = pc_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
        end
    end

    // FIFO pointers; a flush simply rewinds both to slot 0.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= ~wr_ptr_q;
            if (w_pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // FIFO storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (count_q == FIFO_FULL)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_instr_fetch
//  Description : Self-checking bench for rv32_instr_fetch. A stream-level
//                model tracks which PC must be delivered next and when the
//                stream must be flowing; literal checks pin the key cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        imem_req_b;
    logic [11:0] imem_addr_b;
    logic [31:0] imem_rdata_b;
    logic        instr_valid_b;
    logic [31:0] instr_b;
    logic [31:0] instr_pc_b;
    logic        redirect_valid_b = 1'b0;
    logic [31:0] redirect_pc_b    = 32'h0;
    logic        instr_ready_b    = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rv32_instr_fetch #(
        .XPR_LEN(32), .RESET_PC(32'h0000_0000), .IMEM_ADDR_WIDTH(12)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .instr_pc_o(instr_pc)
    );

    rv32_instr_fetch #(
        .XPR_LEN(32), .RESET_PC(32'hFFFF_FFF8), .IMEM_ADDR_WIDTH(12)
    ) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_b), .imem_addr_o(imem_addr_b), .imem_rdata_i(imem_rdata_b),
        .redirect_valid_i(redirect_valid_b), .redirect_pc_i(redirect_pc_b),
        .instr_valid_o(instr_valid_b), .instr_ready_i(instr_ready_b),
        .instr_o(instr_b), .instr_pc_o(instr_pc_b)
    );

    // Memory contents: word k holds 0x1000_0000 + k.
    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return 32'h1000_0000 + {20'h0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Synchronous instruction memories; garbage is returned when not read so
    // that a word presented without a request is noticed.
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        imem_rdata   <= imem_req   ? mem_word(imem_addr)   : (32'hBAD0_0000 ^ 32'(cyc));
        imem_rdata_b <= imem_req_b ? mem_word(imem_addr_b) : (32'hBAD1_0000 ^ 32'(cyc));
    end

    // ------------------------------------------------------------------
    // Stream model for the main instance.
    //   exp_pc     : PC the next delivered instruction must carry
    //   restart_pc : PC the stream (re)started from
    //   since      : cycles since the stream restarted (restart cycle = 0)
    //   held       : instr_ready has been 1 on every cycle since restart
    //   stall      : previous cycle showed valid with ready low
    // ------------------------------------------------------------------
    logic [31:0] exp_pc     = 32'h0;
    logic [31:0] restart_pc = 32'h0;
    logic [31:0] exp_addr;
    int          since      = -100;
    bit          held       = 1'b0;
    bit          stall      = 1'b0;
    logic [31:0] stall_pc;
    logic [31:0] stall_instr;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_req",   {31'b0, imem_req},    32'd0);
            check("rst_valid", {31'b0, instr_valid}, 32'd0);
            exp_pc     = 32'h0;
            restart_pc = 32'h0;
            since      = 0;
            held       = 1'b1;
            stall      = 1'b0;
        end else if (since >= 0) begin
            exp_addr = restart_pc + 32'(4 * since);
            if (redirect_valid) begin
                check("redir_req", {31'b0, imem_req}, 32'd0);
            end else if (since < 2 || (held && instr_ready)) begin
                check("stream_req",  {31'b0, imem_req}, 32'd1);
                check("stream_addr", {20'b0, imem_addr}, {20'b0, exp_addr[13:2]});
            end

            if (since < 2)
                check("early_valid", {31'b0, instr_valid}, 32'd0);
            else if (held)
                check("flow_valid", {31'b0, instr_valid}, 32'd1);

            if (stall) begin
                check("stall_valid", {31'b0, instr_valid}, 32'd1);
                check("stall_pc",    instr_pc, stall_pc);
                check("stall_instr", instr,    stall_instr);
            end

            if (instr_valid === 1'b1) begin
                check("order_pc",    instr_pc, exp_pc);
                check("order_instr", instr,    mem_word(exp_pc[13:2]));
                if (instr_ready) exp_pc = exp_pc + 32'd4;
            end

            stall       = instr_valid && !instr_ready && !redirect_valid;
            stall_pc    = instr_pc;
            stall_instr = instr;
            if (redirect_valid) begin
                exp_pc     = redirect_pc & 32'hFFFF_FFFC;
                restart_pc = exp_pc;
                since      = 0;
                held       = 1'b1;
            end else begin
                since++;
                held = held && instr_ready;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus; cycle 0 is the first cycle with rst low.
    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        repeat (3) tick();

        for (int c = 0; c < 40; c++) begin
            rst            = (c == 27);
            instr_ready    = (c >= 31) ? (c % 3 != 0) : !((c >= 2 && c <= 6) || c == 10);
            redirect_valid = (c == 10) || (c == 16) || (c == 20) || (c == 21);
            redirect_pc    = (c == 10) ? 32'h40 : (c == 16) ? 32'h43 :
                             (c == 20) ? 32'h100 : 32'h200;
            @(negedge clk);
            case (c)
                0: begin
                    check("c0_req",    {31'b0, imem_req},    32'd1);
                    check("c0_addr",   {20'b0, imem_addr},   32'd0);
                    check("c0_valid",  {31'b0, instr_valid}, 32'd0);
                    check("w0_addr",   {20'b0, imem_addr_b}, 32'h0000_0FFE);
                end
                2: begin
                    check("c2_pc",     instr_pc, 32'h0);
                    check("c2_instr",  instr,    32'h1000_0000);
                    check("c2_req",    {31'b0, imem_req}, 32'd0);
                    check("w2_pc",     instr_pc_b, 32'hFFFF_FFF8);
                    check("w2_instr",  instr_b,    32'h1000_0FFE);
                end
                3: begin
                    check("w3_pc",     instr_pc_b, 32'hFFFF_FFFC);
                    check("w3_instr",  instr_b,    32'h1000_0FFF);
                end
                4: begin
                    check("w4_pc",     instr_pc_b, 32'h0000_0000);
                    check("w4_instr",  instr_b,    32'h1000_0000);
                    check("c4_req",    {31'b0, imem_req}, 32'd0);
                end
                6: begin
                    check("c6_valid",  {31'b0, instr_valid}, 32'd1);
                    check("c6_pc",     instr_pc, 32'h0);
                end
                7: begin
                    check("c7_pc",     instr_pc, 32'h0);
                    check("c7_req",    {31'b0, imem_req}, 32'd1);
                    check("c7_addr",   {20'b0, imem_addr}, 32'd2);
                end
                8:  check("c8_pc", instr_pc, 32'h4);
                9:  check("c9_pc", instr_pc, 32'h8);
                11: begin
                    check("r1_valid",  {31'b0, instr_valid}, 32'd0);
                    check("r1_addr",   {20'b0, imem_addr},   32'd16);
                end
                12: check("r2_valid", {31'b0, instr_valid}, 32'd0);
                13: begin
                    check("r3_pc",     instr_pc, 32'h40);
                    check("r3_instr",  instr,    32'h1000_0010);
                end
                16: check("pop_in_r_pc", instr_pc, 32'h4C);
                17: check("r43_addr", {20'b0, imem_addr}, 32'd16);
                19: check("r43_pc",   instr_pc, 32'h40);
                22: check("b2b_addr", {20'b0, imem_addr}, 32'd128);
                24: begin
                    check("b2b_pc",    instr_pc, 32'h200);
                    check("b2b_instr", instr,    32'h1000_0080);
                end
                28: begin
                    check("rst1_valid", {31'b0, instr_valid}, 32'd0);
                    check("rst1_addr",  {20'b0, imem_addr},   32'd0);
                end
                30: begin
                    check("rst3_pc",    instr_pc, 32'h0);
                    check("rst3_instr", instr,    32'h1000_0000);
                end
                default: ;
            endcase
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
